sdram_pro_arbit: RTL

Command-bus arbiter for the SDRAM controller. It sits between the SDRAM device pins and the four command sources: initialisation, auto-refresh, write and read. It holds the bus for initialisation until `init_end`, then grants it to one requester at a time. Refresh has absolute priority, and write/read alternate whenever both are pending. The granted source's cmd/bank/addr are muxed onto the pins, and the DQ tristate is driven only during write data phases.

---
 rtl/sdram_pro_arbit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sdram_pro_arbit.sv
// SDRAM command-bus arbiter: init owns the bus until init_end, then
// refresh has priority and write/read alternate when both are pending.
module sdram_pro_arbit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int BA_W   = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              init_end,
  input  logic              aref_req,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              aref_end,
  input  logic              wr_end,
  input  logic              rd_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_bank,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DATA_W-1:0] sdram_dq,
  output logic [DATA_W-1:0] rd_sdram_data
);

  typedef enum logic [2:0] {
    S_INIT,
    S_ARBIT,
    S_AREF,
    S_WRITE,
    S_READ
  } state_e;

  state_e state_q, state_d;
  logic   last_wr_q, last_wr_d;

  logic [3:0]        cmd_s;
  logic [BA_W-1:0]   ba_s;
  logic [ADDR_W-1:0] addr_s;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= S_INIT;
      last_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
    end
  end

  // last_wr_q steers the write/read tie-break toward the other side
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    unique case (state_q)
      S_INIT: if (init_end) state_d = S_ARBIT;
      S_ARBIT: begin
        if (aref_req)
          state_d = S_AREF;
        else if (wr_req && rd_req)
          state_d = last_wr_q ? S_READ : S_WRITE;
        else if (wr_req)
          state_d = S_WRITE;
        else if (rd_req)
          state_d = S_READ;
      end
      S_AREF: if (aref_end) state_d = S_ARBIT;
      S_WRITE: begin
        if (wr_end) begin
          state_d   = S_ARBIT;
          last_wr_d = 1'b1;
        end
      end
      S_READ: begin
        if (rd_end) begin
          state_d   = S_ARBIT;
          last_wr_d = 1'b0;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    cmd_s  = 4'b0111;
    ba_s   = '1;
    addr_s = '1;
    unique case (state_q)
      S_INIT: begin
        cmd_s  = init_cmd;
        ba_s   = init_bank;
        addr_s = init_addr;
      end
      S_AREF: begin
        cmd_s  = aref_cmd;
        ba_s   = aref_bank;
        addr_s = aref_addr;
      end
      S_WRITE: begin
        cmd_s  = wr_cmd;
        ba_s   = wr_bank;
        addr_s = wr_addr;
      end
      S_READ: begin
        cmd_s  = rd_cmd;
        ba_s   = rd_bank;
        addr_s = rd_addr;
      end
      default: ;
    endcase
  end

  assign aref_en = (state_q == S_AREF);
  assign wr_en   = (state_q == S_WRITE);
  assign rd_en   = (state_q == S_READ);

  assign sdram_cke = 1'b1;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_s;
  assign sdram_ba   = ba_s;
  assign sdram_addr = addr_s;

  assign sdram_dq = (wr_en && wr_sdram_en) ? wr_sdram_data
                                           : {DATA_W{1'bz}};
  assign rd_sdram_data = sdram_dq;

endmodule
